// File: rtl/motor_dac_spi_drv.sv
// Serialises each ramped motor voltage word to the motor-drive DAC as a
// 24-bit {command, data} frame on a 3-wire SPI bus, with a one-deep pending slot.
module motor_dac_spi_drv #(
  parameter int                   MOTOR_VOL = 16,
  parameter int                   CMD_WIDTH = 8,
  parameter logic [CMD_WIDTH-1:0] DAC_CMD   = 8'h30,
  parameter int                   SCLK_DIV  = 4,
  parameter int                   SYNC_GAP  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 motor_dac_en_i,
  input  logic [MOTOR_VOL-1:0] motor_dac_data_i,
  output logic                 dac_sync_n_o,
  output logic                 dac_sclk_o,
  output logic                 dac_sdi_o,
  output logic                 dac_busy_o,
  output logic                 dac_done_o,
  output logic [15:0]          dac_overwrite_cnt_o
);

  localparam int FRAME_W = CMD_WIDTH + MOTOR_VOL;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [7:0]       DIV_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0]       GAP_LAST = 8'(SYNC_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 pend_q, pend_d;
  logic [MOTOR_VOL-1:0] pend_data_q, pend_data_d;
  logic [15:0]          ovr_q, ovr_d;
  logic                 sync_n_q, sync_n_d;
  logic                 sclk_q, sclk_d;
  logic                 sdi_q, sdi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 last_gap;
  logic                 start;
  logic [MOTOR_VOL-1:0] start_word;
  logic                 ovr_inc;

  assign last_gap = (state_q == GAP) && (cnt_q == GAP_LAST);

  // NOTE: every next-state signal is given its hold value before the case
  // statement, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    sync_n_d    = sync_n_q;
    sclk_d      = sclk_q;
    sdi_d       = sdi_q;
    done_d      = 1'b0;
    start       = 1'b0;
    start_word  = motor_dac_data_i;
    ovr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (motor_dac_en_i) start = 1'b1;
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BIT_LAST) begin
            state_d  = GAP;
            sync_n_d = 1'b1;
            sdi_d    = 1'b0;
            done_d   = 1'b1;
          end else begin
            // Data only moves on the rising edge, keeping it stable for the
            // DAC's falling-edge capture.
            sclk_d  = 1'b1;
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            sdi_d   = shift_q[FRAME_W-2];
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (motor_dac_en_i) begin
            start   = 1'b1;
            ovr_inc = pend_q;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            start      = 1'b1;
            start_word = pend_data_q;
            pend_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe arriving mid-frame parks in the pending slot; the frame in
    // flight is never touched.
    if (motor_dac_en_i && (state_q != IDLE) && !last_gap) begin
      pend_d      = 1'b1;
      pend_data_d = motor_dac_data_i;
      ovr_inc     = pend_q;
    end

    if (start) begin
      state_d  = SETUP;
      shift_d  = {DAC_CMD, start_word};
      sdi_d    = DAC_CMD[CMD_WIDTH-1];
      sync_n_d = 1'b0;
      sclk_d   = 1'b0;
      cnt_d    = 8'd0;
      bit_d    = '0;
    end

    ovr_d  = (ovr_inc && (ovr_q != 16'hFFFF)) ? ovr_q + 16'd1 : ovr_q;
    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= 8'd0;
      bit_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      ovr_q       <= 16'd0;
      sync_n_q    <= 1'b1;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovr_q       <= ovr_d;
      sync_n_q    <= sync_n_d;
      sclk_q      <= sclk_d;
      sdi_q       <= sdi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dac_sync_n_o        = sync_n_q;
  assign dac_sclk_o          = sclk_q;
  assign dac_sdi_o           = sdi_q;
  assign dac_busy_o          = busy_q;
  assign dac_done_o          = done_q;
  assign dac_overwrite_cnt_o = ovr_q;

endmodule

// File: tb/tb_motor_dac_spi_drv.sv
// Scoreboard bench: expected frames are queued at stimulus time and compared
// against frames captured from the DAC pins on SCLK falling edges.
`timescale 1ns/1ps
module tb_motor_dac_spi_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en  = 2'b00;
  logic [15:0] data [2];
  logic [1:0]  sync_n, sclk, sdi, busy, done;
  logic [15:0] ovr [2];

  always #5 clk = ~clk;

  // Channel 0: default timing.  Channel 1: fastest legal timing.
  motor_dac_spi_drv u_dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .motor_dac_en_i      (en[0]),
    .motor_dac_data_i    (data[0]),
    .dac_sync_n_o        (sync_n[0]),
    .dac_sclk_o          (sclk[0]),
    .dac_sdi_o           (sdi[0]),
    .dac_busy_o          (busy[0]),
    .dac_done_o          (done[0]),
    .dac_overwrite_cnt_o (ovr[0])
  );

  motor_dac_spi_drv #(.SCLK_DIV(1), .SYNC_GAP(1)) u_dut_fast (
    .clk_i               (clk),
    .rst_i               (rst),
    .motor_dac_en_i      (en[1]),
    .motor_dac_data_i    (data[1]),
    .dac_sync_n_o        (sync_n[1]),
    .dac_sclk_o          (sclk[1]),
    .dac_sdi_o           (sdi[1]),
    .dac_busy_o          (busy[1]),
    .dac_done_o          (done[1]),
    .dac_overwrite_cnt_o (ovr[1])
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [23:0] exp_q0 [$];
  logic [23:0] exp_q1 [$];
  int exp_low    [2] = '{196, 49};
  int exp_period [2] = '{200, 50};
  int exp_busy   [2] = '{200, 100};
  int done_cnt   [2] = '{0, 0};

  // Pin-level monitor for both channels.
  initial begin
    logic        prev_sync [2];
    logic        prev_sclk [2];
    logic        prev_busy [2];
    logic [23:0] shreg     [2];
    logic [23:0] exp_frame;
    int          nbits     [2];
    int          lowcnt    [2];
    int          busycnt   [2];
    int          last_fall [2];
    bit          in_burst  [2];
    int          cyc;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      prev_sync[i] = 1'b1; prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0;
      shreg[i] = '0; nbits[i] = 0; lowcnt[i] = 0; busycnt[i] = 0;
      last_fall[i] = 0; in_burst[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          nbits[i] = 0; lowcnt[i] = 0; busycnt[i] = 0; in_burst[i] = 1'b0;
          prev_sync[i] = 1'b1; prev_sclk[i] = 1'b0; prev_busy[i] = 1'b0;
        end else begin
          if (done[i]) done_cnt[i]++;
          if (!sync_n[i]) begin
            lowcnt[i]++;
            if (prev_sclk[i] && !sclk[i]) begin
              shreg[i] = {shreg[i][22:0], sdi[i]};
              nbits[i]++;
            end
          end
          if (prev_sync[i] && !sync_n[i]) begin
            if (in_burst[i]) check("frame_period", cyc - last_fall[i], exp_period[i]);
            last_fall[i] = cyc;
          end
          if (!prev_sync[i] && sync_n[i]) begin
            if (i == 0) begin
              if (exp_q0.size() == 0) begin check("sb_unexpected_frame0", shreg[i], 0); exp_frame = '0; end
              else exp_frame = exp_q0.pop_front();
            end else begin
              if (exp_q1.size() == 0) begin check("sb_unexpected_frame1", shreg[i], 0); exp_frame = '0; end
              else exp_frame = exp_q1.pop_front();
            end
            check("frame_data", shreg[i], exp_frame);
            check("frame_bits", nbits[i], 24);
            check("sync_low_len", lowcnt[i], exp_low[i]);
            check("done_at_end", done[i], 1'b1);
            nbits[i] = 0; lowcnt[i] = 0; in_burst[i] = 1'b1;
          end
          if (busy[i]) busycnt[i]++;
          else begin
            if (prev_busy[i]) check("busy_len", busycnt[i], exp_busy[i]);
            busycnt[i] = 0; in_burst[i] = 1'b0;
          end
          prev_sync[i] = sync_n[i];
          prev_sclk[i] = sclk[i];
          prev_busy[i] = busy[i];
        end
      end
    end
  end

  // Called at a falling edge; the strobe is sampled at the next rising edge.
  task automatic pulse(input int ch, input logic [15:0] d);
    en[ch]   = 1'b1;
    data[ch] = d;
    @(negedge clk);
    en[ch]   = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input int budget);
    int n = 0;
    while (busy[ch] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy[ch], 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    data[0] = '0;
    data[1] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_sync_n", sync_n[i], 1'b1);
      check("rst_sclk",   sclk[i],   1'b0);
      check("rst_sdi",    sdi[i],    1'b0);
      check("rst_busy",   busy[i],   1'b0);
      check("rst_done",   done[i],   1'b0);
      check("rst_ovr",    ovr[i],    16'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write.
    exp_busy[0] = 200;
    exp_q0.push_back(24'h308000);
    pulse(0, 16'h8000);
    check("t1_sync_fall_latency", sync_n[0], 1'b0);
    wait_idle(0, 1000);
    check("t1_done_cnt", done_cnt[0], 1);
    check("t1_ovr", ovr[0], 16'd0);

    // Back-to-back with one overwrite.
    do_reset();
    exp_busy[0] = 400;
    exp_q0.push_back(24'h301234);
    exp_q0.push_back(24'h300200);
    pulse(0, 16'h1234);
    repeat (48) @(negedge clk);
    pulse(0, 16'h0100);
    repeat (9) @(negedge clk);
    pulse(0, 16'h0200);
    wait_idle(0, 1000);
    check("t2_done_cnt", done_cnt[0], 2);
    check("t2_ovr", ovr[0], 16'd1);

    // Strobe on the final GAP cycle displaces the pending word.
    do_reset();
    repeat (20) @(negedge clk);
    exp_busy[0] = 400;
    exp_q0.push_back(24'h30AAAA);
    exp_q0.push_back(24'h305555);
    pulse(0, 16'hAAAA);
    repeat (99) @(negedge clk);
    pulse(0, 16'h0001);
    repeat (99) @(negedge clk);
    pulse(0, 16'h5555);
    wait_idle(0, 1000);
    check("t3_done_cnt", done_cnt[0], 2);
    check("t3_ovr", ovr[0], 16'd1);

    // Reset in the middle of bit 10.
    do_reset();
    exp_busy[0] = 200;
    pulse(0, 16'hABCD);
    repeat (87) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_async_sync_n", sync_n[0], 1'b1);
    check("t4_async_sclk",   sclk[0],   1'b0);
    check("t4_async_sdi",    sdi[0],    1'b0);
    check("t4_async_busy",   busy[0],   1'b0);
    check("t4_async_done",   done[0],   1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("t4_no_done", done_cnt[0], 0);
    @(negedge clk);
    exp_q0.push_back(24'h30FFFF);
    pulse(0, 16'hFFFF);
    wait_idle(0, 1000);
    check("t4_done_cnt", done_cnt[0], 1);

    // Fastest timing on the second instance, two frames back-to-back.
    exp_busy[1] = 100;
    exp_q1.push_back(24'h3000FF);
    exp_q1.push_back(24'h3000AA);
    pulse(1, 16'h00FF);
    repeat (5) @(negedge clk);
    pulse(1, 16'h00AA);
    wait_idle(1, 500);
    check("t5_done_cnt", done_cnt[1], 2);
    check("t5_ovr", ovr[1], 16'd0);

    // Overwrite counter saturation.
    do_reset();
    force u_dut.ovr_q = 16'hFFFE;
    @(negedge clk);
    release u_dut.ovr_q;
    @(negedge clk);
    check("t6_preload", ovr[0], 16'hFFFE);
    exp_busy[0] = 400;
    exp_q0.push_back(24'h30000A);
    exp_q0.push_back(24'h30000E);
    pulse(0, 16'h000A);
    pulse(0, 16'h000B);
    check("t6_first_pending", ovr[0], 16'hFFFE);
    pulse(0, 16'h000C);
    check("t6_reach_max", ovr[0], 16'hFFFF);
    pulse(0, 16'h000D);
    pulse(0, 16'h000E);
    check("t6_saturated", ovr[0], 16'hFFFF);
    wait_idle(0, 1000);
    check("t6_hold", ovr[0], 16'hFFFF);
    check("t6_done_cnt", done_cnt[0], 2);

    check("sb_drain0", exp_q0.size(), 0);
    check("sb_drain1", exp_q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
